// File: rtl/ifm_window_feeder.sv
// ---------------------------------------------------------------------------
// ifm_window_feeder
//
// Producer side of the KERNAL_SIZE x KERNAL_SIZE convolution line-buffer FIFO.
// On start it reads every IFM channel from the IFM buffer memory in raster
// order and pushes each pixel into the line-buffer FIFO. It tracks the
// row/column of each pushed pixel so that window_valid is raised only when the
// FIFO taps hold a genuine window. Windows that would straddle a row
// wrap-around are suppressed. After the final window of the last channel, done
// pulses for one cycle.
//
// Ports
//   clk, reset     : single clock, synchronous active-high reset
//   start          : begin a full pass (sampled only in IDLE)
//   stall          : downstream back-pressure, blocks new memory reads
//   ifm_sel        : channel currently being read
//   ifm_address    : read address row*IFM_SIZE+col (combinational from counters)
//   ifm_data_in    : memory read data, synchronous memory with 1-cycle latency
//   fifo_enable    : push strobe to the line-buffer FIFO
//   fifo_data_out  : pixel to the FIFO (pass-through of ifm_data_in)
//   window_valid   : FIFO taps hold a valid window this cycle
//   out_address    : output-pixel index of the current window (held otherwise)
//   busy           : pass in progress or pipeline not yet drained
//   done           : one-cycle pulse together with the final window_valid
// ---------------------------------------------------------------------------
module ifm_window_feeder #(
    parameter int DATA_WIDTH             = 32,
    parameter int IFM_SIZE               = 14,
    parameter int IFM_DEPTH              = 3,
    parameter int KERNAL_SIZE            = 5,
    parameter int IFM_SIZE_NEXT          = IFM_SIZE - KERNAL_SIZE + 1,
    parameter int ADDRESS_SIZE_IFM       = $clog2(IFM_SIZE * IFM_SIZE),
    parameter int ADDRESS_SIZE_NEXT_IFM  = $clog2(IFM_SIZE_NEXT * IFM_SIZE_NEXT),
    parameter int NUMBER_OF_BITS_SEL_IFM = (IFM_DEPTH > 1) ? $clog2(IFM_DEPTH) : 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic                              stall,
    output logic [NUMBER_OF_BITS_SEL_IFM-1:0] ifm_sel,
    output logic [ADDRESS_SIZE_IFM-1:0]       ifm_address,
    input  logic [DATA_WIDTH-1:0]             ifm_data_in,
    output logic                              fifo_enable,
    output logic [DATA_WIDTH-1:0]             fifo_data_out,
    output logic                              window_valid,
    output logic [ADDRESS_SIZE_NEXT_IFM-1:0]  out_address,
    output logic                              busy,
    output logic                              done
);

    localparam int CNT_W  = (IFM_SIZE > 1) ? $clog2(IFM_SIZE) : 1;
    localparam int SEL_W  = NUMBER_OF_BITS_SEL_IFM;
    localparam int ADDR_W = ADDRESS_SIZE_IFM;
    localparam int OUT_W  = ADDRESS_SIZE_NEXT_IFM;

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAST_POS  = CNT_W'(IFM_SIZE - 1);
    localparam logic [CNT_W-1:0] WIN_START = CNT_W'(KERNAL_SIZE - 1);
    localparam logic [SEL_W-1:0] SEL_ZERO  = {SEL_W{1'b0}};
    localparam logic [SEL_W-1:0] SEL_ONE   = SEL_W'(1);
    localparam logic [SEL_W-1:0] LAST_SEL  = SEL_W'(IFM_DEPTH - 1);
    localparam logic [OUT_W-1:0] OUT_ZERO  = {OUT_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t             state_q,        state_d;
    logic [CNT_W-1:0]   col_q,          col_d;
    logic [CNT_W-1:0]   row_q,          row_d;
    logic [SEL_W-1:0]   sel_q,          sel_d;
    logic               pending_q,      pending_d;
    logic [CNT_W-1:0]   row_p_q,        row_p_d;
    logic [CNT_W-1:0]   col_p_q,        col_p_d;
    logic               last_p_q,       last_p_d;
    logic               window_valid_q, window_valid_d;
    logic [OUT_W-1:0]   out_address_q,  out_address_d;
    logic               done_q,         done_d;

    logic               issue_s;
    logic               last_pix_s;
    logic [CNT_W-1:0]   win_row_s;
    logic [CNT_W-1:0]   win_col_s;
    logic [OUT_W-1:0]   win_addr_s;

    // Next-state logic: FSM, raster counters, read pipeline and window tracking.
    always_comb begin
        state_d        = state_q;
        col_d          = col_q;
        row_d          = row_q;
        sel_d          = sel_q;
        issue_s        = 1'b0;
        last_pix_s     = (col_q == LAST_POS) && (row_q == LAST_POS) && (sel_q == LAST_SEL);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_READ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                issue_s = !stall;
                if (issue_s && last_pix_s) begin
                    state_d = ST_FLUSH;
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_FLUSH: begin
                // Last read is in flight; its push and window finish on their own.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Raster walk: column, then row, then channel. The channel wraps back
        // to 0 after the last one so a finished pass leaves all counters clear.
        if (issue_s) begin
            if (col_q == LAST_POS) begin
                col_d = CNT_ZERO;
                if (row_q == LAST_POS) begin
                    row_d = CNT_ZERO;
                    if (sel_q == LAST_SEL) begin
                        sel_d = SEL_ZERO;
                    end else begin
                        sel_d = sel_q + SEL_ONE;
                    end
                end else begin
                    row_d = row_q + CNT_ONE;
                end
            end else begin
                col_d = col_q + CNT_ONE;
            end
        end else begin
            col_d = col_q;
            row_d = row_q;
            sel_d = sel_q;
        end

        // The memory answers one cycle after the read, so the position of the
        // read travels alongside it and describes the pixel being pushed.
        pending_d = issue_s;
        if (issue_s) begin
            row_p_d = row_q;
            col_p_d = col_q;
        end else begin
            row_p_d = row_p_q;
            col_p_d = col_p_q;
        end
        last_p_d = issue_s && last_pix_s;

        // A push completes a window only when the pixel sits at least
        // KERNAL_SIZE-1 rows and columns into the map; smaller columns mean the
        // taps span the previous row's tail and must not be reported.
        window_valid_d = pending_q && (row_p_q >= WIN_START) && (col_p_q >= WIN_START);
        win_row_s      = row_p_q - WIN_START;
        win_col_s      = col_p_q - WIN_START;
        win_addr_s     = OUT_W'(win_row_s) * OUT_W'(IFM_SIZE_NEXT) + OUT_W'(win_col_s);
        if (window_valid_d) begin
            out_address_d = win_addr_s;
        end else begin
            out_address_d = out_address_q;
        end

        // The last pixel of the last channel always closes the final window.
        done_d = pending_q && last_p_q;
    end

    // State and pipeline registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            col_q          <= CNT_ZERO;
            row_q          <= CNT_ZERO;
            sel_q          <= SEL_ZERO;
            pending_q      <= 1'b0;
            row_p_q        <= CNT_ZERO;
            col_p_q        <= CNT_ZERO;
            last_p_q       <= 1'b0;
            window_valid_q <= 1'b0;
            out_address_q  <= OUT_ZERO;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            col_q          <= col_d;
            row_q          <= row_d;
            sel_q          <= sel_d;
            pending_q      <= pending_d;
            row_p_q        <= row_p_d;
            col_p_q        <= col_p_d;
            last_p_q       <= last_p_d;
            window_valid_q <= window_valid_d;
            out_address_q  <= out_address_d;
            done_q         <= done_d;
        end
    end

    assign ifm_sel       = sel_q;
    assign ifm_address   = ADDR_W'(row_q) * ADDR_W'(IFM_SIZE) + ADDR_W'(col_q);
    // In-flight data is pushed regardless of stall so nothing read is lost.
    assign fifo_enable   = pending_q;
    assign fifo_data_out = ifm_data_in;
    assign window_valid  = window_valid_q;
    assign out_address   = out_address_q;
    assign done          = done_q;
    assign busy          = (state_q != ST_IDLE) || pending_q || window_valid_q;

endmodule

// File: tb/tb_ifm_window_feeder.sv
// Testbench for ifm_window_feeder: a cycle table for the default run, a
// raster-order reference model for randomized stall/start stimulus, a held
// stall sequence, a mid-pass reset, and a small-parameter instance.
module tb_ifm_window_feeder;

    localparam int S  = 14;
    localparam int K  = 5;
    localparam int D  = 3;
    localparam int N  = S - K + 1;
    localparam int DW = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        stall;
    logic [1:0]  ifm_sel;
    logic [7:0]  ifm_address;
    logic [31:0] ifm_data_in;
    logic        fifo_enable;
    logic [31:0] fifo_data_out;
    logic        window_valid;
    logic [6:0]  out_address;
    logic        busy;
    logic        done;

    // small instance: 6x6, 3x3 kernel, one channel
    logic        s_start;
    logic        s_stall;
    logic [0:0]  s_sel;
    logic [5:0]  s_addr;
    logic [31:0] s_rdata;
    logic        s_fen;
    logic [31:0] s_fdata;
    logic        s_wv;
    logic [3:0]  s_oa;
    logic        s_busy;
    logic        s_done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ifm_window_feeder #(.DATA_WIDTH(DW), .IFM_SIZE(S), .IFM_DEPTH(D), .KERNAL_SIZE(K)) dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .ifm_sel(ifm_sel), .ifm_address(ifm_address), .ifm_data_in(ifm_data_in),
        .fifo_enable(fifo_enable), .fifo_data_out(fifo_data_out),
        .window_valid(window_valid), .out_address(out_address),
        .busy(busy), .done(done)
    );

    ifm_window_feeder #(.DATA_WIDTH(DW), .IFM_SIZE(6), .IFM_DEPTH(1), .KERNAL_SIZE(3)) dut_small (
        .clk(clk), .reset(reset), .start(s_start), .stall(s_stall),
        .ifm_sel(s_sel), .ifm_address(s_addr), .ifm_data_in(s_rdata),
        .fifo_enable(s_fen), .fifo_data_out(s_fdata),
        .window_valid(s_wv), .out_address(s_oa),
        .busy(s_busy), .done(s_done)
    );

    // ---------------- memory models ----------------
    logic [7:0] m_salt = 8'h00;

    function automatic logic [31:0] pix(input int sel, input int addr);
        return {m_salt, 8'(sel), 16'(addr)};
    endfunction

    always @(posedge clk) begin
        ifm_data_in <= pix(int'(ifm_sel), int'(ifm_address));
        s_rdata     <= {26'd0, s_addr};
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Pixels must arrive in raster order over all channels; a pixel at
    // (r,c) with r,c >= K-1 produces a window on the next cycle at
    // (r-K+1)*N + (c-K+1); done accompanies window number D*N*N.
    int m_push;
    int m_win;
    int m_done;
    bit m_wv_exp;
    int m_oa_exp;

    task automatic model_reset();
        m_push   = 0;
        m_win    = 0;
        m_done   = 0;
        m_wv_exp = 1'b0;
        m_oa_exp = 0;
    endtask

    task automatic model_step();
        int sel, rem, r, c;
        check("window_valid", window_valid, m_wv_exp);
        if (m_wv_exp) begin
            check("out_address", out_address, m_oa_exp);
            m_win++;
        end
        check("done", done, m_wv_exp && (m_win == D * N * N));
        if (done) m_done++;
        m_wv_exp = 1'b0;
        if (fifo_enable) begin
            check("push_in_range", m_push < D * S * S, 1);
            sel = m_push / (S * S);
            rem = m_push % (S * S);
            r   = rem / S;
            c   = rem % S;
            check("push_data", fifo_data_out, pix(sel, rem));
            m_wv_exp = (r >= K - 1) && (c >= K - 1);
            m_oa_exp = (r - K + 1) * N + (c - K + 1);
            m_push++;
        end
    endtask

    // ---------------- cycle table for the unstalled run ----------------
    typedef struct {
        int cyc; int addr; int sel; int fen; int wv; int oa; int dn; int bsy;
    } vec_t;
    vec_t tbl[$];

    // mode 0: clean run with table, 1: random stall/start, 2: stall 5 at addr 100
    task automatic run_pass(input int mode, output int done_cyc);
        int cyc;
        int stall_left;
        int rise;
        bit stalled;
        model_reset();
        m_salt     = 8'($urandom);
        cyc        = 0;
        done_cyc   = 0;
        stall_left = 0;
        rise       = 0;
        stalled    = 1'b0;
        start      = 1'b1;
        stall      = 1'b0;
        while (cyc < 3000 && !(done_cyc > 0 && cyc >= done_cyc + 1)) begin
            @(posedge clk);
            #1;
            cyc++;
            model_step();
            if (done && done_cyc == 0) done_cyc = cyc;
            if (mode == 0) begin
                foreach (tbl[i]) begin
                    if (tbl[i].cyc == cyc) begin
                        check("t_addr", ifm_address, tbl[i].addr);
                        check("t_sel", ifm_sel, tbl[i].sel);
                        check("t_fen", fifo_enable, tbl[i].fen);
                        check("t_wv", window_valid, tbl[i].wv);
                        check("t_oa", out_address, tbl[i].oa);
                        check("t_done", done, tbl[i].dn);
                        check("t_busy", busy, tbl[i].bsy);
                    end
                end
            end
            if (mode == 2 && rise > 0 && cyc >= rise && cyc <= rise + 5) begin
                check("stall_addr_hold", ifm_address, 100);
                check("stall_push", fifo_enable, cyc == rise);
            end
            // drive inputs for the next cycle
            start = 1'b0;
            if (mode == 1) begin
                stall = ($urandom_range(0, 99) < 30);
                if (done_cyc == 0) start = ($urandom_range(0, 7) == 0);
            end else if (mode == 2) begin
                if (!stalled && ifm_address == 8'd100) begin
                    stalled    = 1'b1;
                    rise       = cyc;
                    stall_left = 5;
                end
                stall = (stall_left > 0);
                if (stall_left > 0) stall_left--;
                if (cyc == 300 || cyc == 594) start = 1'b1;
            end else begin
                stall = 1'b0;
            end
        end
        start = 1'b0;
        stall = 1'b0;
        check("pass_done_seen", done_cyc > 0, 1);
        check("pass_pushes", m_push, D * S * S);
        check("pass_windows", m_win, D * N * N);
        check("pass_done_count", m_done, 1);
        check("pass_idle_busy", busy, 0);
    endtask

    initial begin
        int dc;
        int cnt;
        int dseen;

        tbl.push_back('{1,   0,   0, 0, 0, 0,  0, 1});
        tbl.push_back('{2,   1,   0, 1, 0, 0,  0, 1});
        tbl.push_back('{61,  60,  0, 1, 0, 0,  0, 1});
        tbl.push_back('{63,  62,  0, 1, 1, 0,  0, 1});
        tbl.push_back('{64,  63,  0, 1, 1, 1,  0, 1});
        tbl.push_back('{73,  72,  0, 1, 0, 9,  0, 1});
        tbl.push_back('{76,  75,  0, 1, 0, 9,  0, 1});
        tbl.push_back('{77,  76,  0, 1, 1, 10, 0, 1});
        tbl.push_back('{196, 195, 0, 1, 1, 97, 0, 1});
        tbl.push_back('{197, 0,   1, 1, 1, 98, 0, 1});
        tbl.push_back('{198, 1,   1, 1, 1, 99, 0, 1});
        tbl.push_back('{199, 2,   1, 1, 0, 99, 0, 1});
        tbl.push_back('{393, 0,   2, 1, 1, 98, 0, 1});
        tbl.push_back('{588, 195, 2, 1, 1, 97, 0, 1});
        tbl.push_back('{589, 0,   0, 1, 1, 98, 0, 1});
        tbl.push_back('{590, 0,   0, 0, 1, 99, 1, 1});
        tbl.push_back('{591, 0,   0, 0, 0, 99, 0, 0});

        reset   = 1'b1;
        start   = 1'b0;
        stall   = 1'b0;
        s_start = 1'b0;
        s_stall = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_fen", fifo_enable, 0);
        check("rst_wv", window_valid, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_addr", ifm_address, 0);
        check("rst_sel", ifm_sel, 0);
        check("rst_oa", out_address, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // scenario 1: clean run against the cycle table
        run_pass(0, dc);
        check("clean_done_cycle", dc, 590);

        // small parameter set: 16 windows, addresses 0..15, then done
        cnt   = 0;
        dseen = 0;
        s_start = 1'b1;
        for (int i = 0; i < 200 && dseen == 0; i++) begin
            @(posedge clk);
            #1;
            s_start = 1'b0;
            if (s_wv) begin
                check("small_oa", s_oa, cnt);
                cnt++;
            end
            if (s_done) begin
                check("small_done_with_last", cnt, 16);
                dseen++;
            end
        end
        check("small_windows", cnt, 16);
        check("small_done_seen", dseen, 1);
        @(posedge clk);
        #1;
        check("small_idle", s_busy, 0);

        // held stall of 5 cycles at address 100; stray start pulses while busy
        run_pass(2, dc);
        check("stall_done_cycle", dc, 595);

        // randomized stall and start noise
        for (int r = 0; r < 3; r++) begin
            run_pass(1, dc);
        end

        // mid-pass reset at cycle 300
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (299) @(posedge clk);
        #1;
        check("pre_reset_busy", busy, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_fen", fifo_enable, 0);
        check("abort_wv", window_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_addr", ifm_address, 0);
        check("abort_done", done, 0);
        repeat (2) @(posedge clk);
        #1;
        check("abort_stays_idle", busy, 0);

        // a fresh start reproduces the clean run
        run_pass(0, dc);
        check("rerun_done_cycle", dc, 590);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
